// File: rtl/cpu_pkg.sv
// Shared CPU constants: memory bus widths, dump header byte and dump FSM states.
// MEM_DUMP_HEADER_EN adds the header-frame states to the dump state enum.
package cpu_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 8;

  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_LATCH    = 3'd2,
    ST_SEND     = 3'd3,
    ST_NEXT     = 3'd4
`ifdef MEM_DUMP_HEADER_EN
    ,
    ST_HDR_LOAD = 3'd5,
    ST_HDR_SEND = 3'd6
`endif
  } dump_state_e;

endpackage

// File: rtl/mem_dump_tx_if.sv
// Data-memory read port between the dump engine (master) and the memory (slave).
interface mem_dump_tx_if #(
  parameter int unsigned ADDR_W = cpu_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = cpu_pkg::DEF_DATA_W
);

  logic              mReadFlag;
  logic [ADDR_W-1:0] dataMemAddrBus;
  logic [DATA_W-1:0] dataMemOutDataBus;

  modport master (
    output mReadFlag,
    output dataMemAddrBus,
    input  dataMemOutDataBus
  );

  modport slave (
    input  mReadFlag,
    input  dataMemAddrBus,
    output dataMemOutDataBus
  );

endinterface

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: a load pulse starts one frame; tx_done_c marks the last stop-bit cycle.
module uart_tx_8n1 #(
  parameter int unsigned CLKS_PER_BIT = 208
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       tx_done_c
);

  localparam int unsigned   CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]    BIT_STOP      = 4'd9;

  logic             active_q, active_d;
  logic [3:0]       bit_q, bit_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_tc;

  assign baud_tc   = (baud_q == BAUD_LAST);
  assign tx_done_c = active_q && baud_tc && (bit_q == BIT_STOP);
  assign tx        = tx_q;

  // bit_q: 0 = start bit, 1..8 = data LSB first, 9 = stop bit
  always_comb begin
    active_d = active_q;
    bit_d    = bit_q;
    baud_d   = baud_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (!active_q) begin
      if (load) begin
        active_d = 1'b1;
        bit_d    = 4'd0;
        baud_d   = '0;
        shift_d  = data;
        tx_d     = 1'b0;
      end
    end else if (baud_tc) begin
      baud_d = '0;
      if (bit_q == BIT_STOP) begin
        active_d = 1'b0;
        bit_d    = 4'd0;
        tx_d     = 1'b1;
      end else if (bit_q == BIT_LAST_DATA) begin
        bit_d = BIT_STOP;
        tx_d  = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        tx_d    = shift_q[0];
        shift_d = {1'b0, shift_q[7:1]};
      end
    end else begin
      baud_d = baud_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      bit_q    <= 4'd0;
      baud_q   <= '0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      baud_q   <= baud_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/mem_dump_tx.sv
// Walks every data-memory address and sends each byte over UART 8N1, lowest address first.
// MEM_DUMP_HEADER_EN: prepend one HEADER_BYTE frame to each dump.
module mem_dump_tx
  import cpu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  mem_dump_tx_if.master mem,
  output logic          UART_TXD,
  output logic          busy,
  output logic          done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mread_q, mread_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_c;
  logic [7:0]        load_data_c;
  logic              tx_done_c;
  logic [DATA_W-1:0] rd_data;

  assign rd_data            = mem.dataMemOutDataBus;
  assign mem.mReadFlag      = mread_q;
  assign mem.dataMemAddrBus = addr_q;
  assign busy               = busy_q;
  assign done               = done_q;

  // mReadFlag stays high through LATCH so the byte is sampled while the read is still enabled
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mread_d     = mread_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_c      = 1'b0;
    load_data_c = 8'(rd_data);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          addr_d = '0;
`ifdef MEM_DUMP_HEADER_EN
          state_d = ST_HDR_LOAD;
`else
          state_d = ST_READ;
          mread_d = 1'b1;
`endif
        end
      end
`ifdef MEM_DUMP_HEADER_EN
      ST_HDR_LOAD: begin
        load_c      = 1'b1;
        load_data_c = HEADER_BYTE;
        state_d     = ST_HDR_SEND;
      end
      ST_HDR_SEND: begin
        if (tx_done_c) begin
          state_d = ST_READ;
          mread_d = 1'b1;
        end
      end
`endif
      ST_READ: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        load_c  = 1'b1;
        mread_d = 1'b0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done_c) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        // compare before increment so the address never wraps mid-dump
        if (addr_q == ADDR_LAST) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_READ;
          addr_d  = addr_q + ADDR_W'(1);
          mread_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mread_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      mread_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mread_q <= mread_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uart_tx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clock     (clock),
    .reset     (reset),
    .load      (load_c),
    .data      (load_data_c),
    .tx        (UART_TXD),
    .tx_done_c (tx_done_c)
  );

endmodule

// File: tb/tb_mem_dump_tx.sv
// Scoreboard bench for mem_dump_tx: expected bytes queued at start, UART decoded by a monitor.
module tb_mem_dump_tx;
  import cpu_pkg::*;

  localparam int unsigned CPB       = 4;
  localparam int unsigned NBYTES    = 16;
  localparam int unsigned FRAME_CYC = 10 * CPB;
  localparam int unsigned BYTE_CYC  = FRAME_CYC + 3;
`ifdef MEM_DUMP_HEADER_EN
  localparam int unsigned HDR_CYC   = FRAME_CYC + 1;
`else
  localparam int unsigned HDR_CYC   = 0;
`endif
  localparam int unsigned DUMP_CYC  = NBYTES * BYTE_CYC + HDR_CYC;

  logic clock = 1'b0;
  logic rst_n;
  logic start;
  logic txd, busy, done;

  mem_dump_tx_if #(.ADDR_W(4), .DATA_W(8)) mif ();

  logic [7:0] mem_arr [NBYTES];
  assign mif.dataMemOutDataBus = mif.mReadFlag ? mem_arr[mif.dataMemAddrBus] : 8'h00;

  mem_dump_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clock    (clock),
    .reset    (rst_n),
    .start    (start),
    .mem      (mif.master),
    .UART_TXD (txd),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int done_cnt = 0;
  int done_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (rst_n && done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  // UART decoder: one sample per clock, CPB samples per bit
  initial begin : monitor
    logic [FRAME_CYC-1:0] samp;
    logic [7:0] got_byte;
    bit aborted, shape_ok;
    forever begin
      @(negedge clock);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        aborted = 0;
        samp    = '0;
        for (int i = 1; i < FRAME_CYC; i++) begin
          @(negedge clock);
          if (rst_n !== 1'b1) begin
            aborted = 1;
            break;
          end
          samp[i] = txd;
        end
        if (!aborted) begin
          shape_ok = 1;
          for (int b = 0; b < 10; b++)
            for (int k = 1; k < CPB; k++)
              if (samp[b*CPB+k] !== samp[b*CPB]) shape_ok = 0;
          if (samp[9*CPB] !== 1'b1) shape_ok = 0;
          for (int b = 0; b < 8; b++) got_byte[b] = samp[(b+1)*CPB];
          check("frame_shape", 32'(shape_ok), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame got=%0h exp=none (cycle %0d)", got_byte, cyc);
          end else begin
            check("frame_byte", 32'(got_byte), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic push_expected();
`ifdef MEM_DUMP_HEADER_EN
    exp_q.push_back(HEADER_BYTE);
`endif
    for (int i = 0; i < NBYTES; i++) exp_q.push_back(mem_arr[i]);
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < NBYTES; i++) mem_arr[i] = 8'($urandom);
  endtask

  // Waits for the next done pulse; optionally pulses start at absolute cycle inject_at
  task automatic wait_done(input int d0, input int budget, input int inject_at, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (inject_at > 0) start = (cyc == inject_at);
      if (done_cnt != d0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_dump(input string tag, input int inject_off);
    int acc, d0;
    bit ok;
    push_expected();
    d0 = done_cnt;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    acc = cyc;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    wait_done(d0, int'(DUMP_CYC) + 200, (inject_off > 0) ? acc + inject_off : 0, ok);
    start = 1'b0;
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    check({tag, "_done_time"}, 32'(done_cyc - acc), 32'(DUMP_CYC));
    repeat (5) @(negedge clock);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_busy_fall"}, 32'(busy), 32'd0);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : stim
    int viol, acc, acc2, d0, target;
    bit ok;
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < NBYTES; i++) mem_arr[i] = 8'h00;

    repeat (3) @(negedge clock);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mread", 32'(mif.mReadFlag), 32'd0);
    check("rst_addr", 32'(mif.dataMemAddrBus), 32'd0);

    rst_n = 1'b1;
    viol = 0;
    repeat (200) begin
      @(negedge clock);
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
          mif.mReadFlag !== 1'b0 || mif.dataMemAddrBus !== 4'd0) viol++;
    end
    check("idle_quiet", 32'(viol), 32'd0);

    for (int i = 0; i < NBYTES; i++) mem_arr[i] = 8'(i * 17);
    run_dump("full", 0);

    randomize_mem();
    mem_arr[0] = 8'h01;
    run_dump("bitorder", 0);

    randomize_mem();
    run_dump("startbusy", int'(HDR_CYC + 5 * BYTE_CYC) + 10);

    // start held high across done: second dump begins on the first IDLE cycle
    randomize_mem();
    push_expected();
    push_expected();
    d0 = done_cnt;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    acc = cyc;
    wait_done(d0, int'(DUMP_CYC) + 200, 0, ok);
    check("held_done1_seen", 32'(ok), 32'd1);
    check("held_done1_time", 32'(done_cyc - acc), 32'(DUMP_CYC));
    acc2 = done_cyc + 1;
    check("held_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(d0 + 1, int'(DUMP_CYC) + 200, 0, ok);
    check("held_done2_seen", 32'(ok), 32'd1);
    check("held_done2_time", 32'(done_cyc - acc2), 32'(DUMP_CYC));
    repeat (5) @(negedge clock);
    check("held_done_count", 32'(done_cnt - d0), 32'd2);
    check("held_queue_empty", 32'(exp_q.size()), 32'd0);

    // reset during a data bit of byte 7 (all-zero byte so TXD is low there)
    randomize_mem();
    mem_arr[7] = 8'h00;
    push_expected();
    d0 = done_cnt;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    acc = cyc;
    target = acc + int'(HDR_CYC + 7 * BYTE_CYC) + 2 + 3 * int'(CPB) + 1;
    ok = 0;
    for (int i = 0; i < int'(DUMP_CYC); i++) begin
      if (cyc >= target) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    check("abort_reached", 32'(ok), 32'd1);
    check("abort_pre_txd", 32'(txd), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_txd_high", 32'(txd), 32'd1);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_mread_low", 32'(mif.mReadFlag), 32'd0);
    exp_q.delete();
    repeat (5) @(negedge clock);
    rst_n = 1'b1;
    repeat (50) @(negedge clock);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_idle_txd", 32'(txd), 32'd1);

    randomize_mem();
    run_dump("fresh", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_dump_tx.md
# mem_dump_tx

Read-only companion to the CPU's data-memory write path. On a start request it walks all 16 data-memory locations through the memory read port, then serializes each byte on UART_TXD as 8N1, lowest address first. It sits at the board top level beside the datapath and `memoria`, and lets the bench or a PC terminal inspect what the program has written.

## Interface

Parameters:
- CLKS_PER_BIT, 208: clock cycles per UART bit. 24 MHz / 115200 baud ≈ 208. Legal range is 2 or more.
- ADDR_W, 4: data-memory address width. The block dumps 2^ADDR_W bytes.
- DATA_W, 8: data-memory word width. Fixed at 8 for the UART frame.

Ports:
- clock, in, 1: single clock. All state is on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: dump request. Sampled only in IDLE.
- mReadFlag, out, 1: memory read enable.
- dataMemAddrBus, out, ADDR_W: memory read address.
- dataMemOutDataBus, in, DATA_W: memory read data. Combinational from address/mReadFlag.
- UART_TXD, out, 1: serial output. Idles high.
- busy, out, 1: high from the cycle after start is accepted until done.
- done, out, 1: one-cycle pulse when the dump completes.

## Operation

- Reset values: UART_TXD=1, mReadFlag=0, dataMemAddrBus=0, busy=0, done=0. State is IDLE and the bit/baud counters are 0.
- State machine:
  - IDLE: on start=1, go to READ with address 0 and busy=1.
  - READ: drive mReadFlag=1 and the address for one cycle.
  - LATCH: capture dataMemOutDataBus into the shift register, deassert mReadFlag, go to START.
  - START: UART_TXD=0 for one bit time.
  - DATA: 8 bit times, LSB first.
  - STOP: UART_TXD=1 for one bit time.
  - NEXT: if the address is the last one (2^ADDR_W−1), pulse done, clear busy and return to IDLE with the address at 0. Otherwise increment the address and go to READ.
- The address counter is ADDR_W bits. The last-address compare happens before the increment, so the counter never wraps mid-dump.
- start while busy is ignored and is not queued. start held high continuously restarts a new dump on the first IDLE cycle after done.
- The memory is never written. The block has no write port.
- Reset asserted mid-frame forces UART_TXD high immediately (asynchronous) and abandons the dump. No done pulse is issued for the aborted dump.
- The top level owns arbitration between this read port and the CPU. The block assumes exclusive read access while busy=1.

## Timing

- start is accepted on the clock edge where start=1 in IDLE. busy rises after that edge.
- READ and LATCH each take exactly one cycle, so each byte carries 2 setup cycles.
- Each frame lasts 10×CLKS_PER_BIT cycles: start bit, 8 data bits, stop bit.
- NEXT takes one cycle.
- Per-byte period: 10×CLKS_PER_BIT+3 cycles.
- Full dump without the header: 16×(10×CLKS_PER_BIT+3) cycles.
- Between frames UART_TXD stays high for 3 cycles minimum.
- done is high only in the cycle after the final stop bit completes. busy falls in that same cycle.
- The baud counter counts 0..CLKS_PER_BIT−1, sized by $clog2(CLKS_PER_BIT). Each bit changes on the counter's terminal count.

## Configuration

- MEM_DUMP_HEADER_EN defined: one header frame 0xA5 is sent immediately after start is accepted and before READ of address 0. It uses the same 8N1 timing and adds 10×CLKS_PER_BIT+1 cycles.
- MEM_DUMP_HEADER_EN undefined: the first frame is the byte at address 0. No header logic or state is compiled.

## Structure

- Shared package cpu_pkg holds:
  - ADDR_W and DATA_W defaults, shared with the datapath and `memoria`;
  - the HEADER_BYTE constant 8'hA5;
  - the dump state enum.
- One sub-module, uart_tx_8n1, owns the baud counter, bit counter, shift register and UART_TXD. Interface: clock, reset, load pulse, 8-bit data, tx, tx_done pulse. The mem_dump_tx FSM handles address sequencing, memory handshake and the header.

## Test plan

Run the bench with CLKS_PER_BIT=4.

- Reset check: assert reset low → UART_TXD=1, busy=0, done=0, mReadFlag=0, dataMemAddrBus=0. Release it and leave start low → nothing changes for 200 cycles.
- Full dump: preload memory[i]=i×0x11, then pulse start for 1 cycle.
  - Decoding UART_TXD yields 0x00,0x11,…,0xFF in address order.
  - done pulses once, 16×43=688 cycles after acceptance.
- Bit order: memory[0]=0x01, dump.
  - The first frame reads 0 (start), 1, then seven 0s, then 1 (stop).
  - Each bit lasts exactly 4 cycles.
- start while busy: pulse start again mid-dump at byte 5 → exactly 16 frames and one done. A start held high through done → a second dump begins on the first IDLE cycle.
- Reset mid-frame: drop reset during bit 3 of byte 7 → UART_TXD=1 the same cycle and no done. After release, start → a fresh dump from address 0.
- With MEM_DUMP_HEADER_EN:
  - The first frame decodes to 0xA5, followed by 16 data frames.
  - done arrives 688+41=729 cycles after acceptance.
